// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and state type for the MIPS multicycle controller
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPE_EX, S_RTYPE_WB, S_BEQ_EX, S_ADDI_EX, S_ADDI_WB, S_J_EX,
        S_FAULT
    } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - R-type funct field to ALU operation decode
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       valid
);

    always_comb begin
        alu_ctrl = ALU_AND;
        valid    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle control FSM with memory wait watchdog and retire counter
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             bad_instr,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(WAIT_LIMIT + 2);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;
    logic [2:0]        dec_ctrl;
    logic              dec_valid;

    mips_alu_decoder u_alu_decoder (
        .funct    (funct),
        .alu_ctrl (dec_ctrl),
        .valid    (dec_valid)
    );

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_ctrl   = ALU_AND;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        bad_instr  = 1'b0;
        halted     = 1'b0;

        // Reset forces every output low so an aborted instruction cannot write anything.
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_ctrl  = ALU_ADD;
                    pc_src    = PCSRC_ALU;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    alu_ctrl  = ALU_ADD;
                    case (opcode)
                        OP_RTYPE:     state_next = S_RTYPE_EX;
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_BEQ:       state_next = S_BEQ_EX;
                        OP_ADDI:      state_next = S_ADDI_EX;
                        OP_J:         state_next = S_J_EX;
                        default: begin
                            bad_instr  = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    alu_ctrl   = ALU_ADD;
                    state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) state_next = S_MEMWB;
                end
                S_MEMWB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end
                end
                S_RTYPE_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_RT;
                    alu_ctrl  = dec_ctrl;
                    if (dec_valid) begin
                        state_next = S_RTYPE_WB;
                    end else begin
                        bad_instr  = 1'b1;
                        state_next = S_FETCH;
                    end
                end
                S_RTYPE_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = 1'b1;
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
                S_BEQ_EX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_RT;
                    alu_ctrl   = ALU_SUB;
                    pc_src     = PCSRC_ALUOUT;
                    pc_write   = zero;
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
                S_ADDI_EX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    alu_ctrl   = ALU_ADD;
                    state_next = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_we     = 1'b1;
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
                S_J_EX: begin
                    pc_src     = PCSRC_JUMP;
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
                S_FAULT: halted = 1'b1;
                default: state_next = S_FETCH;
            endcase

            // Watchdog: a memory stall that reaches the limit traps the controller.
            if (mem_req && !mem_ready && wait_cnt == WAIT_W'(WAIT_LIMIT)) begin
                state_next = S_FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (mem_req && !mem_ready && state_next == state) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed scoreboard bench for the multicycle controller
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       bad_instr;
        logic       halted;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctrl;
    logic        reg_we, reg_dst, mem_to_reg, bad_instr, halted;
    logic [31:0] instr_count;
    ctrl_t       obs;

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_t       exp_q[$];
    logic [31:0] cnt_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_ctrl    (alu_ctrl),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .bad_instr   (bad_instr),
        .halted      (halted),
        .instr_count (instr_count)
    );

    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_ctrl, reg_we, reg_dst, mem_to_reg, bad_instr, halted};

    function automatic ctrl_t c_fetch(input logic rdy);
        ctrl_t c = '0;
        c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.alu_ctrl = 3'b010;
        c.ir_write = rdy; c.pc_write = rdy;
        return c;
    endfunction

    function automatic ctrl_t c_decode(input logic bad);
        ctrl_t c = '0;
        c.alu_src_b = 2'b11; c.alu_ctrl = 3'b010; c.bad_instr = bad;
        return c;
    endfunction

    function automatic ctrl_t c_memadr();
        ctrl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010;
        return c;
    endfunction

    function automatic ctrl_t c_mem(input logic we);
        ctrl_t c = '0;
        c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = we;
        return c;
    endfunction

    function automatic ctrl_t c_wb(input logic dst, input logic m2r);
        ctrl_t c = '0;
        c.reg_we = 1'b1; c.reg_dst = dst; c.mem_to_reg = m2r;
        return c;
    endfunction

    function automatic ctrl_t c_rex(input logic [2:0] op, input logic bad);
        ctrl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_ctrl = op; c.bad_instr = bad;
        return c;
    endfunction

    function automatic ctrl_t c_beq(input logic z);
        ctrl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01; c.pc_write = z;
        return c;
    endfunction

    function automatic ctrl_t c_jump();
        ctrl_t c = '0;
        c.pc_src = 2'b10; c.pc_write = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t c_fault();
        ctrl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    task automatic check_pop();
        ctrl_t       e;
        logic [31:0] ec;
        string       t;
        e  = exp_q.pop_front();
        ec = cnt_q.pop_front();
        t  = tag_q.pop_front();
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s ctrl observed=%h expected=%h", t, obs, e);
        end
        n_checks++;
        assert (instr_count === ec) else begin
            n_fail++;
            $error("FAIL %s instr_count observed=%0d expected=%0d", t, instr_count, ec);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, compare at the falling edge.
    task automatic step(input string tag, input logic rst, input logic rdy,
                        input ctrl_t e, input logic [31:0] cnt);
        reset     = rst;
        mem_ready = rdy;
        exp_q.push_back(e);
        cnt_q.push_back(cnt);
        tag_q.push_back(tag);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'b001000; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("reset0", 1'b1, 1'b1, '0, 32'd0);
        step("reset1", 1'b1, 1'b0, '0, 32'd0);

        opcode = 6'b001000;
        step("addi_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd0);
        step("addi_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd0);
        step("addi_ex",     1'b0, 1'b1, c_memadr(), 32'd0);
        step("addi_wb",     1'b0, 1'b1, c_wb(1'b0, 1'b0), 32'd0);

        opcode = 6'b100011;
        step("lw_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd1);
        step("lw_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd1);
        step("lw_memadr", 1'b0, 1'b1, c_memadr(), 32'd1);
        step("lw_wait0",  1'b0, 1'b0, c_mem(1'b0), 32'd1);
        step("lw_wait1",  1'b0, 1'b0, c_mem(1'b0), 32'd1);
        step("lw_memrd",  1'b0, 1'b1, c_mem(1'b0), 32'd1);
        step("lw_wb",     1'b0, 1'b1, c_wb(1'b0, 1'b1), 32'd1);

        opcode = 6'b000100; zero = 1'b1;
        step("beq1_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd2);
        step("beq1_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd2);
        step("beq1_ex",     1'b0, 1'b1, c_beq(1'b1), 32'd2);
        zero = 1'b0;
        step("beq0_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd3);
        step("beq0_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd3);
        step("beq0_ex",     1'b0, 1'b1, c_beq(1'b0), 32'd3);

        opcode = 6'b000000; funct = 6'b100010;
        step("sub_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd4);
        step("sub_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd4);
        step("sub_ex",     1'b0, 1'b1, c_rex(3'b110, 1'b0), 32'd4);
        step("sub_wb",     1'b0, 1'b1, c_wb(1'b1, 1'b0), 32'd4);
        funct = 6'b101010;
        step("slt_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd5);
        step("slt_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd5);
        step("slt_ex",     1'b0, 1'b1, c_rex(3'b111, 1'b0), 32'd5);
        step("slt_wb",     1'b0, 1'b1, c_wb(1'b1, 1'b0), 32'd5);

        opcode = 6'b000010;
        step("j_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd6);
        step("j_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd6);
        step("j_ex",     1'b0, 1'b1, c_jump(), 32'd6);

        opcode = 6'b111111;
        step("badop_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd7);
        step("badop_decode", 1'b0, 1'b1, c_decode(1'b1), 32'd7);
        opcode = 6'b000000; funct = 6'b000111;
        step("badfn_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd7);
        step("badfn_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd7);
        step("badfn_ex",     1'b0, 1'b1, c_rex(3'b000, 1'b1), 32'd7);

        opcode = 6'b101011;
        step("sw_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd7);
        step("sw_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd7);
        step("sw_memadr", 1'b0, 1'b1, c_memadr(), 32'd7);
        step("sw_memwr",  1'b0, 1'b1, c_mem(1'b1), 32'd7);

        step("swr_fetch",  1'b0, 1'b1, c_fetch(1'b1), 32'd8);
        step("swr_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd8);
        step("swr_memadr", 1'b0, 1'b1, c_memadr(), 32'd8);
        step("swr_memwr",  1'b0, 1'b0, c_mem(1'b1), 32'd8);
        step("swr_reset",  1'b1, 1'b1, '0, 32'd8);
        step("swr_after",  1'b0, 1'b0, c_fetch(1'b0), 32'd0);
        step("swr_refetch", 1'b0, 1'b1, c_fetch(1'b1), 32'd0);

        opcode = 6'b000010;
        step("j2_decode", 1'b0, 1'b1, c_decode(1'b0), 32'd0);
        step("j2_ex",     1'b0, 1'b1, c_jump(), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step($sformatf("stall_%0d", i), 1'b0, 1'b0, c_fetch(1'b0), 32'd1);
        end
        step("fault0", 1'b0, 1'b0, c_fault(), 32'd1);
        step("fault1", 1'b0, 1'b1, c_fault(), 32'd1);
        step("fault2", 1'b0, 1'b0, c_fault(), 32'd1);
        step("fault_reset", 1'b1, 1'b0, '0, 32'd1);
        step("post_fault",  1'b0, 1'b0, c_fetch(1'b0), 32'd0);

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
